// File: rtl/dmem_pkg.sv
// Shared types and constants for the latency-modelled data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_BITS  = 8 * WORD_BYTES;
  localparam int unsigned BYTE_OFS_W = $clog2(WORD_BYTES);
  localparam int unsigned WORD_IDX_W = 32 - BYTE_OFS_W;

  typedef struct packed {
    logic                  is_write;
    logic [WORD_IDX_W-1:0] index;
    logic [WORD_BITS-1:0]  wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write enable and a registered, resettable read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_BITS-1:0]  wdata_i,
  output logic [WORD_BITS-1:0]  rdata_o
);

  logic [WORD_BITS-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_BITS-1:0] rdata_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_latency.sv
// Word-addressed data memory returning a one-cycle completion pulse a fixed LATENCY after acceptance.
module data_mem_latency
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_wire,
  input  logic        MemWrite_wire,
  input  logic [31:0] MemAddress_wire,
  input  logic [31:0] MemWriteData_wire,
  output logic [31:0] Datamem_wire,
  output logic        MemValid_wire
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_latency: LATENCY must be in 1..15");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH >= WORD_IDX_W) begin : g_bad_addr_width
    $error("data_mem_latency: ADDR_WIDTH out of range");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  dmem_req_t  req_q, req_d, acc_req;
  logic       acc_en;
  logic       valid_q;
  logic       we, re;
  logic       unused_bits;

  // With LATENCY=1 the access happens on the accepting edge, so it uses the
  // incoming request rather than the latched copy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    acc_en  = 1'b0;
    acc_req = req_q;
    case (state_q)
      IDLE: begin
        if (MemWrite_wire || MemRead_wire) begin
          req_d = '{is_write: MemWrite_wire,
                    index:    MemAddress_wire[31:BYTE_OFS_W],
                    wdata:    MemWriteData_wire};
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = DONE;
            acc_en  = 1'b1;
            acc_req = req_d;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= (state_d == DONE);
    end
  end

  // Reset gates the access so an in-flight write is dropped, not committed.
  assign we = acc_en && acc_req.is_write && !rst;
  assign re = acc_en && !acc_req.is_write && !rst;

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (we),
    .re_i   (re),
    .addr_i (acc_req.index[ADDR_WIDTH-1:0]),
    .wdata_i(acc_req.wdata),
    .rdata_o(Datamem_wire)
  );

  assign MemValid_wire = valid_q;
  assign unused_bits   = ^{MemAddress_wire[BYTE_OFS_W-1:0],
                           acc_req.index[WORD_IDX_W-1:ADDR_WIDTH]};

endmodule

// File: tb/tb_data_mem_latency.sv
// Randomized self-checking bench for data_mem_latency against a word-array reference model.
module tb_data_mem_latency;

  localparam int unsigned AW    = 10;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, rd1, wr1;
  logic [31:0] addr, wdata, rdata, addr1, wdata1, rdata1;
  logic        valid, valid1;

  always #5 clk = ~clk;

  data_mem_latency #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .MemRead_wire(rd), .MemWrite_wire(wr),
    .MemAddress_wire(addr), .MemWriteData_wire(wdata),
    .Datamem_wire(rdata), .MemValid_wire(valid)
  );

  data_mem_latency #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .MemRead_wire(rd1), .MemWrite_wire(wr1),
    .MemAddress_wire(addr1), .MemWriteData_wire(wdata1),
    .Datamem_wire(rdata1), .MemValid_wire(valid1)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  // Presents one request on the LATENCY=4 instance from an idle cycle and follows it
  // until it is back in IDLE; optionally wiggles the request wires while busy.
  task automatic txn(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit scramble, input string tag);
    int unsigned i;
    i = widx(a);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    if (w) ref_mem[i] = d;
    else if (r) last_rd = ref_mem[i];
    for (int k = 0; k <= int'(LAT) + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (scramble && k < int'(LAT)) begin
        wr = 1'b1; addr = 32'h20; wdata = $urandom;
      end else begin
        wr = 1'b0;
      end
      check({tag, ":valid"}, 32'(valid), 32'(k == int'(LAT)));
      if (k == int'(LAT)) check({tag, ":data"}, rdata, last_rd);
    end
  endtask

  // Holds a request on the LATENCY=1 instance for six cycles: pulses every other cycle.
  task automatic hold1(input bit r, input bit w, input logic [31:0] exp_data, input string tag);
    rd1 = r; wr1 = w;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check({tag, ":valid"}, 32'(valid1), 32'(k % 2 == 0));
      if (k % 2 == 0) check({tag, ":data"}, rdata1, exp_data);
    end
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  int unsigned pool [8];

  initial begin
    rst = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", rdata, 32'h0);

    txn(0, 1, 32'h40, 32'hDEADBEEF, 0, "raw_wr");
    txn(1, 0, 32'h40, 32'h0, 0, "raw_rd");
    txn(0, 1, 32'h0000_0004, 32'h1234, 0, "alias_wr");
    txn(1, 0, 32'h0000_1007, 32'h0, 0, "alias_rd");
    txn(1, 1, 32'h8, 32'hA5A5, 0, "both");
    txn(1, 0, 32'h8, 32'h0, 0, "both_rd");

    txn(0, 1, 32'h20, 32'h5555, 0, "busy_pre");
    txn(0, 1, 32'h100, 32'hCAFE, 1, "busy");
    txn(1, 0, 32'h20, 32'h0, 0, "busy_chk");
    txn(1, 0, 32'h100, 32'h0, 0, "busy_tgt");

    txn(0, 1, 32'h10, 32'h0, 0, "rst_pre");
    wr = 1'b1; addr = 32'h10; wdata = 32'hFFFF;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    check("rst_mid_data", rdata, 32'h0);
    for (int k = 0; k <= int'(LAT) + 1; k++) begin
      check("rst_mid_valid", 32'(valid), 32'd0);
      @(posedge clk); #1;
    end
    txn(1, 0, 32'h10, 32'h0, 0, "rst_rd");

    for (int p = 0; p < 8; p++) begin
      pool[p] = $urandom_range(0, DEPTH - 1);
      txn(0, 1, ($urandom << (AW + 2)) | (pool[p] << 2) | $urandom_range(0, 3),
          $urandom, 0, "rnd_init");
    end
    for (int n = 0; n < 24; n++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      txn(op != 1, op != 0,
          ($urandom << (AW + 2)) | (pool[$urandom_range(0, 7)] << 2) | $urandom_range(0, 3),
          $urandom, 0, "rnd");
    end

    addr1 = 32'h30; wdata1 = 32'h77;
    hold1(0, 1, 32'h0, "lat1_wr");
    hold1(1, 0, 32'h77, "lat1_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
